branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Execute-side counterpart of the fetch-stage branch target buffer. It tracks every prediction issued at fetch in a small in-order queue and pops the matching entry when the instruction resolves in EX. It compares the predicted direction and target against the actual outcome. On a mismatch it drives pipeline flush, a redirect PC, and the BTB write/invalidate port that keeps the BTB trained.

Parameters:
ADDR_W, 64, width of PC / target addresses (matches `BUS_ADDR_MEM)
DEPTH, 4, in-flight prediction queue entries (power of two, >=2)
FLUSH_CYC, 2, cycles flush_o stays asserted after a mispredict (>=1)
CNT_W, 32, width of mispredict counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
fq_push_i  in  1  fetch issued an instruction; record its prediction
fq_pc_i  in  ADDR_W  fetched PC
fq_pred_taken_i  in  1  BTB predicted taken (`JMP_EN)
fq_pred_target_i  in  ADDR_W  BTB predicted target
fq_full_o  out  1  queue full; fetch must stall
ex_valid_i  in  1  instruction resolved in EX this cycle; pop head
ex_is_branch_i  in  1  resolved instruction is a jump/branch
ex_taken_i  in  1  actual direction
ex_target_i  in  ADDR_W  actual target (valid when ex_taken_i)
flush_o  out  1  squash younger instructions
redirect_valid_o  out  1  one-cycle pulse: load redirect_pc_o into PC
redirect_pc_o  out  ADDR_W  correct next PC
btb_rec_en_o  out  1  one-cycle pulse: write entry to BTB
btb_rec_pc_o  out  ADDR_W  PC to record
btb_rec_target_o  out  ADDR_W  target to record
btb_inv_o  out  1  one-cycle pulse: invalidate BTB entry for btb_rec_pc_o
mispredict_cnt_o  out  CNT_W  saturating mispredict count
err_o  out  1  sticky: queue overflow or underflow

Behaviour:
- Reset: queue empty, FSM = IDLE, all outputs 0, counter 0, err_o 0.
- Queue: FIFO of {pc, pred_taken, pred_target} with wrap-around pointers. fq_full_o is combinational from occupancy == DEPTH.
- Push and pop in the same cycle while full: both take effect; occupancy unchanged.
- Push while full without a pop: dropped, err_o set.
- Pop while empty: ignored (no resolve), err_o set.
- FSM IDLE: on ex_valid_i with a non-empty queue, compare the head entry against the actual outcome.
- Mispredict occurs if any of:
  - pred_taken != (ex_is_branch_i & ex_taken_i);
  - both taken and pred_target != ex_target_i.
- On mispredict (registered, visible at cycle N+1 for pop at cycle N):
  - flush_o = 1 and redirect_valid_o = 1.
  - redirect_pc_o = actual taken ? ex_target_i : head.pc + 4.
  - Counter increments, saturating at all-ones.
  - Go to FLUSH.
- BTB update, same cycle as redirect:
  - Actual taken and mismatch -> btb_rec_en_o = 1 with {head.pc, ex_target_i}.
  - Predicted taken but actually not taken (or not a branch) -> btb_inv_o = 1 with btb_rec_pc_o = head.pc.
  - btb_rec_en_o and btb_inv_o are never both 1.
- Correct prediction: pop only; no flush, redirect, or BTB pulse.
- FSM FLUSH:
  - flush_o is held for FLUSH_CYC cycles total; redirect and BTB pulses last only the first of these.
  - The queue is cleared on entry; pushes and ex_valid_i are ignored with no err_o.
  - Returns to IDLE after FLUSH_CYC cycles.
- Reset mid-FLUSH: immediate return to the reset state.
- Address arithmetic is modulo 2^ADDR_W (head.pc + 4 wraps).

Decomposition:
- Shared defines file: `JMP_EN/`JMP_DIS, `JMP_RIGHT/`JMP_ERROR, `BUS_ADDR_MEM, `MEM_ADDR_ZERO, and the FSM state encodings (RESOLVE_IDLE, RESOLVE_FLUSH).
- One sub-module, pred_fifo: a parameterised DEPTH x (2*ADDR_W+1) synchronous FIFO with full/empty outputs.
- Compare logic, FSM and counter live in the top.

Test Plan:
- Push pc=0x100 pred not-taken; resolve taken, target=0x200 -> at N+1: flush_o=1, redirect_pc_o=0x200, btb_rec_en_o=1 {0x100,0x200}, cnt=1, flush_o held 2 cycles.
- Push pc=0x100 pred taken 0x200; resolve not-taken -> redirect_pc_o=0x104, btb_inv_o=1, btb_rec_pc_o=0x100.
- Pred taken 0x200; actual taken 0x300 -> redirect_pc_o=0x300, btb_rec_en_o=1 target 0x300; pred taken 0x300, actual taken 0x300 -> no flush, cnt unchanged.
- Push 4 entries -> fq_full_o=1. Simultaneous push+pop -> still full, err_o=0. Fifth push alone -> err_o=1. Pop with empty queue after reset -> err_o=1.
- Mispredict with 3 entries queued, then pushes during FLUSH -> queue empty after FLUSH, pushes ignored. Assert rst during FLUSH -> next cycle all outputs 0.
- Force counter to all-ones (CNT_W=4 build) and mispredict again -> stays 4'hF.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared constants and FSM encoding for branch resolution
package branch_resolve_unit_pkg;

  localparam int BUS_ADDR_MEM = 64;

  localparam logic JMP_EN  = 1'b1;
  localparam logic JMP_DIS = 1'b0;

  // Outcome of comparing a prediction against the resolved branch
  localparam logic JMP_RIGHT = 1'b0;
  localparam logic JMP_ERROR = 1'b1;

  localparam logic [BUS_ADDR_MEM-1:0] MEM_ADDR_ZERO = '0;

  typedef enum logic {
    RESOLVE_IDLE,
    RESOLVE_FLUSH
  } resolve_state_e;

endpackage

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - in-order queue of fetch-time predictions awaiting resolution
module pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves fetch predictions in EX, drives flush/redirect and BTB training
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W    = BUS_ADDR_MEM,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fq_push_i,
  input  logic [ADDR_W-1:0] fq_pc_i,
  input  logic              fq_pred_taken_i,
  input  logic [ADDR_W-1:0] fq_pred_target_i,
  output logic              fq_full_o,
  input  logic              ex_valid_i,
  input  logic              ex_is_branch_i,
  input  logic              ex_taken_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              btb_rec_en_o,
  output logic [ADDR_W-1:0] btb_rec_pc_o,
  output logic [ADDR_W-1:0] btb_rec_target_o,
  output logic              btb_inv_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o,
  output logic              err_o
);

  localparam int ENTRY_W = 2 * ADDR_W + 1;
  localparam int FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  resolve_state_e      state;
  logic [FC_W-1:0]     flush_cnt;

  logic [ENTRY_W-1:0]  head;
  logic [ADDR_W-1:0]   head_pc;
  logic                head_taken;
  logic [ADDR_W-1:0]   head_target;
  logic                q_full;
  logic                q_empty;

  logic                idle;
  logic                resolve;
  logic                underflow;
  logic                drop_push;
  logic                actual_taken;
  logic                jmp_result;
  logic                mispredict;

  assign head_pc     = head[2*ADDR_W:ADDR_W+1];
  assign head_taken  = head[ADDR_W];
  assign head_target = head[ADDR_W-1:0];

  assign idle         = (state == RESOLVE_IDLE);
  assign resolve      = idle & ex_valid_i & ~q_empty;
  assign underflow    = idle & ex_valid_i & q_empty;
  assign drop_push    = idle & fq_push_i & q_full & ~resolve;
  // A taken non-branch is treated as fall-through
  assign actual_taken = ex_is_branch_i & ex_taken_i;

  always_comb begin
    jmp_result = JMP_RIGHT;
    if ((head_taken != actual_taken) ||
        (head_taken == JMP_EN && actual_taken == JMP_EN && head_target != ex_target_i)) begin
      jmp_result = JMP_ERROR;
    end
  end

  assign mispredict = resolve & (jmp_result == JMP_ERROR);
  assign fq_full_o  = q_full;

  // The mispredict clears every younger prediction, so it overrides push/pop
  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pred_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (mispredict),
    .push  (idle & fq_push_i & ~mispredict),
    .wdata ({fq_pc_i, fq_pred_taken_i, fq_pred_target_i}),
    .pop   (resolve),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RESOLVE_IDLE;
      flush_cnt        <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= ADDR_W'(MEM_ADDR_ZERO);
      btb_rec_en_o     <= 1'b0;
      btb_rec_pc_o     <= ADDR_W'(MEM_ADDR_ZERO);
      btb_rec_target_o <= ADDR_W'(MEM_ADDR_ZERO);
      btb_inv_o        <= 1'b0;
      mispredict_cnt_o <= '0;
      err_o            <= 1'b0;
    end else begin
      redirect_valid_o <= 1'b0;
      btb_rec_en_o     <= 1'b0;
      btb_inv_o        <= 1'b0;
      if (drop_push || underflow) begin
        err_o <= 1'b1;
      end
      case (state)
        RESOLVE_IDLE: begin
          if (mispredict) begin
            state            <= RESOLVE_FLUSH;
            flush_cnt        <= FC_W'(FLUSH_CYC - 1);
            flush_o          <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= actual_taken ? ex_target_i : head_pc + ADDR_W'(4);
            btb_rec_pc_o     <= head_pc;
            if (actual_taken == JMP_EN) begin
              btb_rec_en_o     <= 1'b1;
              btb_rec_target_o <= ex_target_i;
            end else begin
              btb_inv_o        <= (head_taken == JMP_EN) && (actual_taken == JMP_DIS);
              btb_rec_target_o <= ADDR_W'(MEM_ADDR_ZERO);
            end
            if (mispredict_cnt_o != {CNT_W{1'b1}}) begin
              mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
            end
          end
        end
        RESOLVE_FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= RESOLVE_IDLE;
            flush_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= RESOLVE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fq_push_i;
  logic [63:0] fq_pc_i;
  logic        fq_pred_taken_i;
  logic [63:0] fq_pred_target_i;
  logic        fq_full_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic        ex_taken_i;
  logic [63:0] ex_target_i;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        btb_rec_en_o;
  logic [63:0] btb_rec_pc_o;
  logic [63:0] btb_rec_target_o;
  logic        btb_inv_o;
  logic [3:0]  mispredict_cnt_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(
    .ADDR_W    (64),
    .DEPTH     (4),
    .FLUSH_CYC (2),
    .CNT_W     (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fq_push_i        (fq_push_i),
    .fq_pc_i          (fq_pc_i),
    .fq_pred_taken_i  (fq_pred_taken_i),
    .fq_pred_target_i (fq_pred_target_i),
    .fq_full_o        (fq_full_o),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .btb_rec_en_o     (btb_rec_en_o),
    .btb_rec_pc_o     (btb_rec_pc_o),
    .btb_rec_target_o (btb_rec_target_o),
    .btb_inv_o        (btb_inv_o),
    .mispredict_cnt_o (mispredict_cnt_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    fq_push_i = 1'b1; fq_pc_i = pc; fq_pred_taken_i = tk; fq_pred_target_i = tgt;
    tick();
    fq_push_i = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [63:0] tgt);
    ex_valid_i = 1'b1; ex_is_branch_i = br; ex_taken_i = tk; ex_target_i = tgt;
    tick();
    ex_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fq_push_i = 0; fq_pc_i = 0; fq_pred_taken_i = 0; fq_pred_target_i = 0;
    ex_valid_i = 0; ex_is_branch_i = 0; ex_taken_i = 0; ex_target_i = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_flush", flush_o, 0);
    chk("rst_redir", redirect_valid_o, 0);
    chk("rst_rpc", redirect_pc_o, 0);
    chk("rst_rec_en", btb_rec_en_o, 0);
    chk("rst_inv", btb_inv_o, 0);
    chk("rst_cnt", mispredict_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_full", fq_full_o, 0);

    resolve(1, 1, 64'h200);
    chk("underflow_err", err_o, 1);
    chk("underflow_noflush", flush_o, 0);
    do_reset();
    chk("err_cleared", err_o, 0);

    // predicted not-taken, actually taken
    push(64'h100, 0, 64'h0);
    resolve(1, 1, 64'h200);
    chk("t1_flush", flush_o, 1);
    chk("t1_redir", redirect_valid_o, 1);
    chk("t1_rpc", redirect_pc_o, 64'h200);
    chk("t1_rec_en", btb_rec_en_o, 1);
    chk("t1_rec_pc", btb_rec_pc_o, 64'h100);
    chk("t1_rec_tgt", btb_rec_target_o, 64'h200);
    chk("t1_inv", btb_inv_o, 0);
    chk("t1_cnt", mispredict_cnt_o, 1);
    tick();
    chk("t1_flush_c2", flush_o, 1);
    chk("t1_redir_c2", redirect_valid_o, 0);
    chk("t1_rec_en_c2", btb_rec_en_o, 0);
    tick();
    chk("t1_flush_end", flush_o, 0);

    // predicted taken, actually not taken
    push(64'h100, 1, 64'h200);
    resolve(1, 0, 64'h0);
    chk("t2_flush", flush_o, 1);
    chk("t2_rpc", redirect_pc_o, 64'h104);
    chk("t2_inv", btb_inv_o, 1);
    chk("t2_rec_en", btb_rec_en_o, 0);
    chk("t2_rec_pc", btb_rec_pc_o, 64'h100);
    chk("t2_cnt", mispredict_cnt_o, 2);
    tick(); tick();

    // taken with wrong target, then taken with right target
    push(64'h100, 1, 64'h200);
    resolve(1, 1, 64'h300);
    chk("t3_rpc", redirect_pc_o, 64'h300);
    chk("t3_rec_en", btb_rec_en_o, 1);
    chk("t3_rec_tgt", btb_rec_target_o, 64'h300);
    chk("t3_inv", btb_inv_o, 0);
    chk("t3_cnt", mispredict_cnt_o, 3);
    tick(); tick();
    push(64'h100, 1, 64'h300);
    resolve(1, 1, 64'h300);
    chk("t3_ok_flush", flush_o, 0);
    chk("t3_ok_redir", redirect_valid_o, 0);
    chk("t3_ok_rec_en", btb_rec_en_o, 0);
    chk("t3_ok_cnt", mispredict_cnt_o, 3);

    // predicted taken on a non-branch
    push(64'h400, 1, 64'h500);
    resolve(0, 1, 64'h500);
    chk("nb_rpc", redirect_pc_o, 64'h404);
    chk("nb_inv", btb_inv_o, 1);
    chk("nb_rec_en", btb_rec_en_o, 0);
    chk("nb_cnt", mispredict_cnt_o, 4);
    tick(); tick();

    // pc + 4 wraps at the top of the address space
    push(64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h10);
    resolve(1, 0, 64'h0);
    chk("wrap_rpc", redirect_pc_o, 64'h0);
    chk("wrap_cnt", mispredict_cnt_o, 5);
    tick(); tick();

    push(64'h600, 0, 64'h0);
    resolve(1, 0, 64'h0);
    chk("nt_ok_flush", flush_o, 0);
    chk("nt_ok_cnt", mispredict_cnt_o, 5);

    // fill, push+pop while full, overflow
    push(64'h10, 0, 0);
    push(64'h20, 0, 0);
    push(64'h30, 0, 0);
    chk("not_full_3", fq_full_o, 0);
    push(64'h40, 0, 0);
    chk("full_4", fq_full_o, 1);
    fq_push_i = 1; fq_pc_i = 64'h50; fq_pred_taken_i = 0; fq_pred_target_i = 0;
    ex_valid_i = 1; ex_is_branch_i = 1; ex_taken_i = 0; ex_target_i = 0;
    tick();
    fq_push_i = 0; ex_valid_i = 0;
    chk("pushpop_full", fq_full_o, 1);
    chk("pushpop_err", err_o, 0);
    chk("pushpop_flush", flush_o, 0);
    push(64'h60, 0, 0);
    chk("overflow_err", err_o, 1);
    chk("overflow_full", fq_full_o, 1);
    resolve(1, 0, 0);
    resolve(1, 0, 0);
    resolve(1, 0, 0);
    chk("drain_flush", flush_o, 0);
    resolve(1, 1, 64'h900);
    chk("order_rec_pc", btb_rec_pc_o, 64'h50);
    chk("order_rpc", redirect_pc_o, 64'h900);
    tick(); tick();
    chk("order_empty", fq_full_o, 0);
    do_reset();

    // mispredict with 3 queued; pushes and resolves during FLUSH are ignored
    push(64'hA00, 1, 64'hB00);
    push(64'hA10, 0, 0);
    push(64'hA20, 0, 0);
    resolve(1, 0, 0);
    chk("q3_rpc", redirect_pc_o, 64'hA04);
    chk("q3_inv", btb_inv_o, 1);
    chk("q3_cnt", mispredict_cnt_o, 1);
    fq_push_i = 1; fq_pc_i = 64'hC00; fq_pred_taken_i = 0;
    ex_valid_i = 1; ex_is_branch_i = 1; ex_taken_i = 1; ex_target_i = 64'hD00;
    tick(); tick();
    fq_push_i = 0; ex_valid_i = 0;
    chk("q3_flush_done", flush_o, 0);
    chk("q3_err", err_o, 0);
    chk("q3_cnt_hold", mispredict_cnt_o, 1);
    resolve(1, 1, 64'hD00);
    chk("q3_empty_err", err_o, 1);
    chk("q3_empty_noflush", flush_o, 0);
    do_reset();

    // reset in the middle of FLUSH
    push(64'h100, 0, 0);
    resolve(1, 1, 64'h200);
    chk("mid_flush", flush_o, 1);
    do_reset();
    chk("mid_rst_flush", flush_o, 0);
    chk("mid_rst_redir", redirect_valid_o, 0);
    chk("mid_rst_rpc", redirect_pc_o, 0);
    chk("mid_rst_rec_en", btb_rec_en_o, 0);
    chk("mid_rst_rec_pc", btb_rec_pc_o, 0);
    chk("mid_rst_rec_tgt", btb_rec_target_o, 0);
    chk("mid_rst_cnt", mispredict_cnt_o, 0);
    tick();
    chk("mid_rst_flush_stays", flush_o, 0);

    // counter saturation
    for (int i = 1; i <= 16; i++) begin
      push(64'h100, 0, 0);
      resolve(1, 1, 64'h200);
      if (i == 14) chk("sat_14", mispredict_cnt_o, 14);
      if (i == 15) chk("sat_15", mispredict_cnt_o, 15);
      tick(); tick();
    end
    chk("sat_hold", mispredict_cnt_o, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
